// File: rtl/multi_pulse_sync_pkg.sv
// Shared types for multi_pulse_sync: edge modes, report bundle,
// and the round-robin pick helper.
package multi_pulse_sync_pkg;

  typedef enum logic [1:0] {
    RISE = 2'b00,
    FALL = 2'b01,
    BOTH = 2'b10,
    OFF  = 2'b11
  } edge_mode_e;

  localparam int RPT_ID_W  = 5;
  localparam int RPT_CNT_W = 32;

  typedef struct packed {
    logic [RPT_ID_W-1:0]  id;
    logic [RPT_CNT_W-1:0] cnt;
    logic                 ovf;
  } rpt_t;

  // Lowest requesting index at or after ptr, wrapping modulo n.
  function automatic logic [RPT_ID_W-1:0] rr_pick(
    input logic [31:0] req,
    input int          ptr,
    input int          n
  );
    logic [RPT_ID_W-1:0] win;
    logic                found;
    int                  idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (!found && req[idx[4:0]]) begin
          win   = idx[RPT_ID_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/multi_pulse_sync_chan.sv
// One capture channel: sync chain, stability filter, edge qualify.
// Ports: clk, n_rst, async_in, mode -> hit (same-cycle), pulse (registered).
module pulse_sync_chan
  import multi_pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       async_in,
  input  edge_mode_e mode,
  output logic       hit,
  output logic       pulse
);

  localparam int FW =
    (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic [FW-1:0]          fcnt_q;
  logic                   s;
  logic                   diff;
  logic                   toggle;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    diff   = (s != lvl_q);
    toggle = diff && (fcnt_q == FW'(FILTER_CYCLES));
    hit    = 1'b0;
    unique case (mode)
      RISE: hit = toggle && !lvl_q;
      FALL: hit = toggle && lvl_q;
      BOTH: hit = toggle;
      OFF:  hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      fcnt_q <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      pulse  <= hit;
      if (toggle) begin
        lvl_q  <= s;
        fcnt_q <= '0;
      end else if (diff) begin
        fcnt_q <= fcnt_q + 1'b1;
      end else begin
        fcnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_pulse_sync.sv
// Multi-channel async event capture with per-channel counters and a
// round-robin ready/valid report slot draining the counts.
module multi_pulse_sync
  import multi_pulse_sync_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_W         = 4,
  localparam int ID_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [CHANNELS-1:0]   async_in,
  input  logic [2*CHANNELS-1:0] edge_mode,
  output logic [CHANNELS-1:0]   pulse,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [ID_W-1:0]       rpt_id,
  output logic [CNT_W-1:0]      rpt_cnt,
  output logic                  rpt_ovf
);

  logic [CHANNELS-1:0] hit;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     ptr_nx;
  logic [31:0]         req;
  logic [RPT_ID_W-1:0] win;
  logic [ID_W-1:0]     win_idx;
  logic                load;
  rpt_t                slot_q;
  logic                slot_unused;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pulse_sync_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_chan (
      .clk     (clk),
      .n_rst   (n_rst),
      .async_in(async_in[g]),
      .mode    (edge_mode_e'(edge_mode[2*g +: 2])),
      .hit     (hit[g]),
      .pulse   (pulse[g])
    );
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      req[i] = |cnt_q[i];
    end
    win     = rr_pick(req, int'(ptr_q), CHANNELS);
    win_idx = win[ID_W-1:0];
    load    = (!rpt_valid || rpt_ready) && (|req);
    if (int'(win_idx) + 1 == CHANNELS) ptr_nx = '0;
    else ptr_nx = win_idx + 1'b1;
  end

  // A hit on the channel being drained restarts its count at 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load && win_idx == ID_W'(i)) begin
          cnt_q[i] <= CNT_W'(hit[i]);
          ovf_q[i] <= 1'b0;
        end else if (hit[i]) begin
          if (&cnt_q[i]) ovf_q[i] <= 1'b1;
          else cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_q    <= '0;
      rpt_valid <= 1'b0;
      ptr_q     <= '0;
    end else if (load) begin
      slot_q.id  <= win;
      slot_q.cnt <= RPT_CNT_W'(cnt_q[win_idx]);
      slot_q.ovf <= ovf_q[win_idx];
      rpt_valid  <= 1'b1;
      ptr_q      <= ptr_nx;
    end else if (rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

  assign rpt_id      = slot_q.id[ID_W-1:0];
  assign rpt_cnt     = slot_q.cnt[CNT_W-1:0];
  assign rpt_ovf     = slot_q.ovf;
  assign slot_unused = ^slot_q;

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Bench for multi_pulse_sync: unfiltered and filtered instances
// share stimulus and are compared against a behavioural model.
module tb_multi_pulse_sync;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] ain = '0;
  logic [7:0] mode = '0;
  logic       ready = 1'b1;

  logic [3:0] p0, p1, c0, c1;
  logic       v0, v1, o0, o1;
  logic [1:0] id0, id1;

  always #5 clk = ~clk;

  multi_pulse_sync #(
    .CHANNELS(4), .SYNC_STAGES(2),
    .FILTER_CYCLES(0), .CNT_W(4)
  ) u0 (
    .clk(clk), .n_rst(n_rst), .async_in(ain),
    .edge_mode(mode), .pulse(p0), .rpt_valid(v0),
    .rpt_ready(ready), .rpt_id(id0), .rpt_cnt(c0),
    .rpt_ovf(o0)
  );

  multi_pulse_sync #(
    .CHANNELS(4), .SYNC_STAGES(2),
    .FILTER_CYCLES(3), .CNT_W(4)
  ) u1 (
    .clk(clk), .n_rst(n_rst), .async_in(ain),
    .edge_mode(mode), .pulse(p1), .rpt_valid(v1),
    .rpt_ready(ready), .rpt_id(id1), .rpt_cnt(c1),
    .rpt_ovf(o1)
  );

  int checks = 0;
  int errors = 0;

  task automatic ck(string tag, logic [31:0] obs,
                    logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic int fc(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Model state
  logic [3:0] ahist[$];
  logic [3:0] syhist[$];
  bit m_lvl  [2][4];
  bit m_pulse[2][4];
  bit m_ovf  [2][4];
  int m_cnt  [2][4];
  bit m_v [2];
  int m_id[2];
  int m_c [2];
  bit m_o [2];
  int m_ptr[2];

  bit lastv[2];
  int lastid[2];
  int log0[$];
  int log1[$];
  int obs_p[2][4];
  int obs_v[2];

  task automatic model_reset();
    ahist.delete();
    syhist.delete();
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_lvl[k][ch] = 0;
        m_pulse[k][ch] = 0;
        m_ovf[k][ch] = 0;
        m_cnt[k][ch] = 0;
      end
      m_v[k] = 0; m_id[k] = 0; m_c[k] = 0;
      m_o[k] = 0; m_ptr[k] = 0;
      lastv[k] = 0;
    end
  endtask

  task automatic clr_obs();
    for (int k = 0; k < 2; k++) begin
      obs_v[k] = 0;
      for (int ch = 0; ch < NCH; ch++) obs_p[k][ch] = 0;
    end
  endtask

  // Accepted level changes: last fc+1 synced samples all differ
  // from the current accepted level.
  task automatic model_edge();
    logic [3:0] s;
    int  win, idx;
    bit  all, hit, b;
    s = (ahist.size() >= SS) ? ahist[ahist.size()-SS] : 4'b0;
    ahist.push_back(ain);
    if (ahist.size() > 8) void'(ahist.pop_front());
    syhist.push_back(s);
    if (syhist.size() > 8) void'(syhist.pop_front());
    for (int k = 0; k < 2; k++) begin
      win = -1;
      if (!m_v[k] || ready) begin
        for (int j = 0; j < NCH; j++) begin
          idx = (m_ptr[k] + j) % NCH;
          if (win < 0 && m_cnt[k][idx] > 0) win = idx;
        end
      end
      if (win >= 0) begin
        m_v[k] = 1;
        m_id[k] = win;
        m_c[k] = m_cnt[k][win];
        m_o[k] = m_ovf[k][win];
        m_ptr[k] = (win + 1) % NCH;
      end else if (ready) begin
        m_v[k] = 0;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        all = 1;
        for (int d = 0; d <= fc(k); d++) begin
          b = (d < syhist.size()) ?
              syhist[syhist.size()-1-d][ch] : 1'b0;
          if (b == m_lvl[k][ch]) all = 0;
        end
        case (mode[2*ch +: 2])
          2'd0: hit = all && !m_lvl[k][ch];
          2'd1: hit = all && m_lvl[k][ch];
          2'd2: hit = all;
          default: hit = 0;
        endcase
        if (all) m_lvl[k][ch] = !m_lvl[k][ch];
        m_pulse[k][ch] = hit;
        if (win == ch) begin
          m_cnt[k][ch] = hit ? 1 : 0;
          m_ovf[k][ch] = 0;
        end else if (hit) begin
          if (m_cnt[k][ch] == CMAX) m_ovf[k][ch] = 1;
          else m_cnt[k][ch]++;
        end
      end
    end
  endtask

  task automatic chk(int k, logic [3:0] p, logic v,
                     logic [1:0] id, logic [3:0] c, logic o);
    logic [3:0] ep;
    for (int ch = 0; ch < NCH; ch++) ep[ch] = m_pulse[k][ch];
    ck($sformatf("pulse_u%0d", k), 32'(p), 32'(ep));
    ck($sformatf("valid_u%0d", k), 32'(v), 32'(m_v[k]));
    if (m_v[k])
      ck($sformatf("rpt_u%0d", k), 32'({id, c, o}),
         32'({2'(m_id[k]), 4'(m_c[k]), m_o[k]}));
    for (int ch = 0; ch < NCH; ch++)
      if (p[ch] === 1'b1) obs_p[k][ch]++;
    if (v === 1'b1) obs_v[k]++;
    lastv[k] = (v === 1'b1);
    lastid[k] = int'(id);
  endtask

  task automatic step();
    if (n_rst && ready) begin
      if (lastv[0]) log0.push_back(lastid[0]);
      if (lastv[1]) log1.push_back(lastid[1]);
    end
    @(posedge clk);
    if (n_rst) model_edge();
    @(negedge clk);
    chk(0, p0, v0, id0, c0, o0);
    chk(1, p1, v1, id1, c1, o1);
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic chk_log(string tag, int q[$], int e[$]);
    ck({tag, "_len"}, 32'(q.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      ck($sformatf("%s_%0d", tag, i),
         (i < q.size()) ? 32'(q[i]) : 32'hffff_ffff,
         32'(e[i]));
  endtask

  initial begin
    model_reset();
    clr_obs();
    @(negedge clk);
    ck("rst_u0", 32'({p0, v0, id0, c0, o0}), 32'd0);
    ck("rst_u1", 32'({p1, v1, id1, c1, o1}), 32'd0);
    steps(2);

    // ch0 rising: latency and first report
    n_rst = 1'b1;
    ain[0] = 1'b1;
    steps(2);
    ck("lat_e2", 32'(p0[0]), 32'd0);
    step();
    ck("lat_e3", 32'(p0[0]), 32'd1);
    ck("val_e3", 32'(v0), 32'd0);
    step();
    ck("pulse_e4", 32'(p0[0]), 32'd0);
    ck("val_e4", 32'(v0), 32'd1);
    ck("rpt_e4", 32'({id0, c0, o0}), 32'({2'd0, 4'd1, 1'b0}));
    steps(2);
    ck("flt_lat_e6", 32'(p1[0]), 32'd1);
    step();
    ck("flt_rpt_e7", 32'({v1, id1, c1, o1}),
       32'({1'b1, 2'd0, 4'd1, 1'b0}));
    ain[0] = 1'b0;
    steps(10);

    // glitch rejection on ch1
    clr_obs();
    ain[1] = 1'b1;
    steps(2);
    ain[1] = 1'b0;
    steps(12);
    ck("glitch_u1", 32'(obs_p[1][1]), 32'd0);
    ck("glitch_u0", 32'(obs_p[0][1]), 32'd1);
    clr_obs();
    ain[1] = 1'b1;
    steps(5);
    ain[1] = 1'b0;
    steps(12);
    ck("pass5_u1", 32'(obs_p[1][1]), 32'd1);

    // saturation with ready held low on ch2
    ready = 1'b0;
    repeat (20) begin
      ain[2] = 1'b1;
      steps(5);
      ain[2] = 1'b0;
      steps(5);
    end
    steps(3);
    ck("sat_first_u0", 32'({v0, id0, c0, o0}),
       32'({1'b1, 2'd2, 4'd1, 1'b0}));
    ck("sat_first_u1", 32'({v1, id1, c1, o1}),
       32'({1'b1, 2'd2, 4'd1, 1'b0}));
    ready = 1'b1;
    step();
    ck("sat_next_u0", 32'({v0, id0, c0, o0}),
       32'({1'b1, 2'd2, 4'd15, 1'b1}));
    ck("sat_next_u1", 32'({v1, id1, c1, o1}),
       32'({1'b1, 2'd2, 4'd15, 1'b1}));
    steps(3);

    // round-robin order
    ain[3] = 1'b1;
    steps(8);
    ain[3] = 1'b0;
    steps(8);
    log0.delete();
    log1.delete();
    ain = 4'b1011;
    steps(10);
    ain = 4'b0000;
    steps(8);
    chk_log("rr_u0", log0, '{0, 1, 3});
    chk_log("rr_u1", log1, '{0, 1, 3});
    log0.delete();
    log1.delete();
    ain = 4'b0101;
    steps(10);
    ain = 4'b0000;
    steps(8);
    chk_log("wrap_u0", log0, '{0, 2});
    chk_log("wrap_u1", log1, '{0, 2});

    // edge modes on ch3
    mode[7:6] = 2'b10;
    steps(4);
    clr_obs();
    repeat (4) begin
      ain[3] = ~ain[3];
      steps(8);
    end
    ck("both_u0", 32'(obs_p[0][3]), 32'd4);
    ck("both_u1", 32'(obs_p[1][3]), 32'd4);
    mode[7:6] = 2'b11;
    clr_obs();
    repeat (3) begin
      ain[3] = ~ain[3];
      steps(8);
    end
    ck("off_u0", 32'(obs_p[0][3]), 32'd0);
    ck("off_u1", 32'(obs_p[1][3]), 32'd0);
    clr_obs();
    mode[7:6] = 2'b00;
    steps(8);
    mode[7:6] = 2'b01;
    steps(8);
    mode[7:6] = 2'b10;
    steps(8);
    ck("modesw_u0", 32'(obs_p[0][3]), 32'd0);
    ck("modesw_u1", 32'(obs_p[1][3]), 32'd0);
    mode[7:6] = 2'b00;
    ain[3] = 1'b0;
    steps(10);

    // reset while a report is held and counts pending
    ready = 1'b0;
    ain = 4'b0011;
    steps(8);
    ck("pre_rst_u0", 32'(v0), 32'd1);
    ck("pre_rst_u1", 32'(v1), 32'd1);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    ck("mid_rst_u0", 32'({p0, v0, id0, c0, o0}), 32'd0);
    ck("mid_rst_u1", 32'({p1, v1, id1, c1, o1}), 32'd0);
    @(negedge clk);
    ain = 4'b0000;
    ready = 1'b1;
    steps(2);
    n_rst = 1'b1;
    clr_obs();
    steps(12);
    ck("post_rst_u0", 32'(obs_v[0]), 32'd0);
    ck("post_rst_u1", 32'(obs_v[1]), 32'd0);

    // randomized traffic against the model
    repeat (800) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 5) == 0) ain[ch] = ~ain[ch];
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) mode = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
